truth_table_checker: RTL and testbench

Synchronous response checker for the 4-input, 1-output combinational circuits of Exercise 2. It samples the four input bits applied to a circuit under test, together with that circuit's output, and compares the output to a golden 16-entry truth table. It records which minterms have been exercised, counts mismatches and captures the first failing minterm. It declares pass or fail once all 16 minterms have been seen, which gives the exhaustive stimulus sequence a self-checking receiving end.

---
 rtl/truth_table_checker.sv | 111 +++++++++++
 tb/tb_truth_table_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Response checker for 4-input/1-output circuits: compares sampled outputs to a golden table,
// tracks minterm coverage and mismatches, and reports pass/fail once all 16 minterms are seen.
module truth_table_checker #(
   parameter logic [15:0] TRUTH = 16'h6996,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   input  logic             first_in,
   input  logic             second_in,
   input  logic             third_in,
   input  logic             fourth_in,
   input  logic             dut_out,
   output logic             ready,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [3:0]       first_err_idx,
   output logic [15:0]      covered
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [15:0]        covered_q, covered_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic               first_err_valid_q, first_err_valid_d;
   logic [3:0]         first_err_idx_q, first_err_idx_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [3:0]         idx;
   logic               mismatch;

   always_comb begin
      idx               = {first_in, second_in, third_in, fourth_in};
      mismatch          = (dut_out != TRUTH[idx]);
      state_d           = state_q;
      covered_d         = covered_q;
      err_count_d       = err_count_q;
      first_err_valid_d = first_err_valid_q;
      first_err_idx_d   = first_err_idx_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d           = StRun;
               covered_d         = '0;
               err_count_d       = '0;
               first_err_valid_d = 1'b0;
               first_err_idx_d   = '0;
            end
         end
         StRun: begin
            if (vec_valid) begin
               covered_d = covered_q | (16'd1 << idx);
               if (mismatch) begin
                  if (err_count_q != {CNT_W{1'b1}}) begin
                     err_count_d = err_count_q + 1'b1;
                  end
                  if (!first_err_valid_q) begin
                     first_err_valid_d = 1'b1;
                     first_err_idx_d   = idx;
                  end
               end
               if (covered_d == 16'hFFFF) begin
                  state_d = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Status flags are derived from next state so they are registered alongside it.
      ready_d = (state_d == StRun);
      done_d  = (state_d == StDone);
      pass_d  = done_d && (err_count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= StIdle;
         covered_q         <= '0;
         err_count_q       <= '0;
         first_err_valid_q <= 1'b0;
         first_err_idx_q   <= '0;
         ready_q           <= 1'b0;
         done_q            <= 1'b0;
         pass_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         covered_q         <= covered_d;
         err_count_q       <= err_count_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_idx_q   <= first_err_idx_d;
         ready_q           <= ready_d;
         done_q            <= done_d;
         pass_q            <= pass_d;
      end
   end

   assign ready           = ready_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_count_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_idx   = first_err_idx_q;
   assign covered         = covered_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed scenarios plus random traffic against a
// behavioural model; a second instance with CNT_W=2 exercises counter saturation.
module tb_truth_table_checker;

   localparam logic [15:0] TRUTH = 16'h6996;

   logic        clk = 1'b0;
   logic        rst, start, vec_valid, first_in, second_in, third_in, fourth_in, dut_out;
   logic        ready, done, pass, first_err_valid;
   logic [7:0]  err_count;
   logic [3:0]  first_err_idx;
   logic [15:0] covered;
   logic        s_ready, s_done, s_pass, s_fv;
   logic [1:0]  s_err;
   logic [3:0]  s_fi;
   logic [15:0] s_cov;

   int checks = 0;
   int failures = 0;

   // Behavioural model: 0 = idle, 1 = running, 2 = finished.
   int          m_state = 0;
   int          m_err = 0;
   logic [15:0] m_cov = '0;
   logic        m_fv = 1'b0;
   logic [3:0]  m_fi = '0;

   always #5 clk = ~clk;

   truth_table_checker #(.TRUTH(TRUTH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
      .first_in(first_in), .second_in(second_in), .third_in(third_in), .fourth_in(fourth_in),
      .dut_out(dut_out), .ready(ready), .done(done), .pass(pass), .err_count(err_count),
      .first_err_valid(first_err_valid), .first_err_idx(first_err_idx), .covered(covered)
   );

   truth_table_checker #(.TRUTH(TRUTH), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
      .first_in(first_in), .second_in(second_in), .third_in(third_in), .fourth_in(fourth_in),
      .dut_out(dut_out), .ready(s_ready), .done(s_done), .pass(s_pass), .err_count(s_err),
      .first_err_valid(s_fv), .first_err_idx(s_fi), .covered(s_cov)
   );

   logic [57:0] obs;
   assign obs = {ready, done, pass, err_count, first_err_valid, first_err_idx, covered,
                 s_ready, s_done, s_pass, s_err, s_fv, s_fi, s_cov};

   function automatic logic [57:0] model_vec();
      logic       r, d, p;
      logic [7:0] e8;
      logic [1:0] e2;
      r  = (m_state == 1);
      d  = (m_state == 2);
      p  = d && (m_err == 0);
      e8 = (m_err > 255) ? 8'd255 : 8'(m_err);
      e2 = (m_err > 3) ? 2'd3 : 2'(m_err);
      return {r, d, p, e8, m_fv, m_fi, m_cov, r, d, p, e2, m_fv, m_fi, m_cov};
   endfunction

   function automatic void model_step(input logic r, s, v, input logic [3:0] idx, input logic o);
      if (r) begin
         m_state = 0; m_err = 0; m_cov = '0; m_fv = 1'b0; m_fi = '0;
      end else if (m_state != 1) begin
         if (s) begin
            m_state = 1; m_err = 0; m_cov = '0; m_fv = 1'b0; m_fi = '0;
         end
      end else if (v) begin
         m_cov[idx] = 1'b1;
         if (o != TRUTH[idx]) begin
            m_err = m_err + 1;
            if (!m_fv) begin
               m_fv = 1'b1;
               m_fi = idx;
            end
         end
         if (m_cov == 16'hFFFF) m_state = 2;
      end
   endfunction

   // One clock: drive on the falling edge, advance the model at the rising edge, settle 1ns.
   task automatic cyc(input logic r, s, v, input logic [3:0] idx, input logic o);
      @(negedge clk);
      rst = r; start = s; vec_valid = v; dut_out = o;
      {first_in, second_in, third_in, fourth_in} = idx;
      @(posedge clk);
      model_step(r, s, v, idx, o);
      #1;
   endtask

   task automatic send(input logic [3:0] idx, input logic bad);
      cyc(1'b0, 1'b0, 1'b1, idx, TRUTH[idx] ^ bad);
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (obs !== 58'd0) begin
         failures++;
         $display("FAIL reset_values got=%h want=0", obs);
      end
   endtask

   task automatic test_all_correct();
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      checks++;
      if (ready !== 1'b1 || covered !== 16'h0) begin
         failures++;
         $display("FAIL start_ready got ready=%b cov=%h want ready=1 cov=0000", ready, covered);
      end
      for (int i = 0; i < 16; i++) begin
         send(4'(i), 1'b0);
         if (i == 14) begin
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
               failures++;
               $display("FAIL early_done got done=%b ready=%b want done=0 ready=1", done, ready);
            end
         end
      end
      checks++;
      if ({done, ready, pass, err_count, first_err_valid, covered} !== {3'b101, 8'd0, 1'b0, 16'hFFFF})
      begin
         failures++;
         $display("FAIL all_correct got done=%b ready=%b pass=%b err=%0d fv=%b cov=%h",
                  done, ready, pass, err_count, first_err_valid, covered);
      end
      checks++;
      if (obs !== model_vec()) begin
         failures++;
         $display("FAIL all_correct_model got=%h want=%h", obs, model_vec());
      end
   endtask

   task automatic test_two_errors();
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 16; i++) send(4'(i), (i == 5) || (i == 12));
      checks++;
      if ({done, pass, err_count, first_err_valid, first_err_idx} !== {2'b10, 8'd2, 1'b1, 4'd5})
      begin
         failures++;
         $display("FAIL two_errors got done=%b pass=%b err=%0d fv=%b fi=%0d want 1 0 2 1 5",
                  done, pass, err_count, first_err_valid, first_err_idx);
      end
   endtask

   task automatic test_reverse_gaps();
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 15; i >= 0; i--) begin
         if (i == 3) begin
            send(4'd3, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 4'd9, 1'b1);
            send(4'd3, 1'b1);
         end
         if (i == 0) begin
            checks++;
            if (done !== 1'b0 || covered !== 16'hFFFE) begin
               failures++;
               $display("FAIL reverse_pre_done got done=%b cov=%h want 0 fffe", done, covered);
            end
         end
         send(4'(i), 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 4'(i + 1), 1'b0);
      end
      checks++;
      if ({done, pass, err_count, first_err_idx} !== {2'b10, 8'd2, 4'd3}) begin
         failures++;
         $display("FAIL reverse_gaps got done=%b pass=%b err=%0d fi=%0d want 1 0 2 3",
                  done, pass, err_count, first_err_idx);
      end
   endtask

   task automatic test_ignored();
      for (int i = 0; i < 4; i++) send(4'(i), 1'b1);
      checks++;
      if ({done, err_count, covered} !== {1'b1, 8'd2, 16'hFFFF}) begin
         failures++;
         $display("FAIL done_hold got done=%b err=%0d cov=%h want 1 2 ffff", done, err_count, covered);
      end
      cyc(1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
      checks++;
      if ({ready, done, pass, err_count, first_err_valid, first_err_idx, covered} !==
          {3'b100, 8'd0, 1'b0, 4'd0, 16'd0}) begin
         failures++;
         $display("FAIL restart_clear got ready=%b done=%b err=%0d fv=%b fi=%0d cov=%h",
                  ready, done, err_count, first_err_valid, first_err_idx, covered);
      end
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      send(4'd6, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 4'd4, 1'b1);
      checks++;
      if ({ready, err_count, covered} !== {1'b1, 8'd0, 16'd0}) begin
         failures++;
         $display("FAIL idle_drop got ready=%b err=%0d cov=%h want 1 0 0000", ready, err_count, covered);
      end
   endtask

   task automatic test_reset_midrun();
      for (int i = 0; i < 7; i++) send(4'(i), i == 4);
      checks++;
      if ({err_count, first_err_idx, covered} !== {8'd1, 4'd4, 16'h007F}) begin
         failures++;
         $display("FAIL midrun got err=%0d fi=%0d cov=%h want 1 4 007f", err_count, first_err_idx, covered);
      end
      cyc(1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
      checks++;
      if (obs !== 58'd0) begin
         failures++;
         $display("FAIL midrun_reset got=%h want=0", obs);
      end
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 16; i++) send(4'(15 - i), 1'b0);
      checks++;
      if ({done, pass, err_count} !== {2'b11, 8'd0}) begin
         failures++;
         $display("FAIL after_reset_run got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
      end
   endtask

   task automatic test_saturation();
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 16; i++) send(4'((i + 9) % 16), 1'b1);
      checks++;
      if ({s_done, s_pass, s_err, s_fi, err_count} !== {2'b10, 2'd3, 4'd9, 8'd16}) begin
         failures++;
         $display("FAIL saturation got done=%b pass=%b sat_err=%0d fi=%0d err=%0d want 1 0 3 9 16",
                  s_done, s_pass, s_err, s_fi, err_count);
      end
   endtask

   task automatic test_random();
      logic       r, s, v, o;
      logic [3:0] idx;
      int         bad_cycles;
      bad_cycles = 0;
      for (int n = 0; n < 1500; n++) begin
         r   = ($urandom_range(0, 199) == 0);
         s   = ($urandom_range(0, 7) == 0);
         v   = ($urandom_range(0, 3) != 0);
         idx = 4'($urandom_range(0, 15));
         o   = TRUTH[idx] ^ ($urandom_range(0, 15) == 0);
         cyc(r, s, v, idx, o);
         checks++;
         if (obs !== model_vec()) begin
            failures++;
            bad_cycles++;
            if (bad_cycles <= 5) $display("FAIL random cycle=%0d got=%h want=%h", n, obs, model_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; vec_valid = 1'b0; dut_out = 1'b0;
      first_in = 1'b0; second_in = 1'b0; third_in = 1'b0; fourth_in = 1'b0;
      test_reset();
      test_all_correct();
      test_two_errors();
      test_reverse_gaps();
      test_ignored();
      test_reset_midrun();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
